uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver: deserialises 8E1 frames (1 start, 8 data LSB-first, 1 even-parity bit, 1 stop) from an asynchronous serial line into parallel bytes. Line rate is BAUDRATE on a BASE_FREQ system clock, sampling at mid-bit. It is the receive end of the team's UART link. It presents each byte with a one-cycle valid strobe plus parity and framing error flags.

Parameters:
BASE_FREQ, 50_000_000, system clock frequency in Hz
BAUDRATE, 115_200, line bit rate in bits/s
CLKS_PER_BIT, BASE_FREQ/BAUDRATE (434), clock cycles per bit (derived localparam)
HALF_BIT, CLKS_PER_BIT/2 (217), cycles from start-edge detect to start-bit mid-sample (derived localparam)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
serial_in  input  1  asynchronous serial line, idle high
data  output  8  last received byte, held until next frame completes
data_valid  output  1  one-cycle pulse: data, parity_err and frame_err updated
parity_err  output  1  even-parity mismatch on the last frame, held
frame_err  output  1  stop bit sampled low on the last frame, held
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset, asynchronous, while rst=1:
  - data=0x00, data_valid=0, parity_err=0, frame_err=0, busy=0.
  - Synchroniser flops=1, counters=0, state=IDLE.
- Mid-frame reset abandons the frame; no data_valid is issued.
- Input: serial_in passes through a 2-flop synchroniser (rx_s), reset to 1. All decisions use rx_s, so there are 2 cycles of input latency.
- Bit counter clk_ctr is 32-bit, counts 0..limit-1 and then resets to 0. Bit index is 0..7.
- States and transitions:
  - IDLE: busy=0. When rx_s=0, go to START with clk_ctr=0.
  - START: count to HALF_BIT-1 and sample rx_s there.
    - If rx_s=1 (glitch/false start), return to IDLE with no strobe.
    - If rx_s=0, go to DATA with clk_ctr=0 and bit index=0.
  - DATA: after CLKS_PER_BIT cycles, sample rx_s into the shift register at the current bit index (LSB first).
    - Index 7 goes to PARITY; otherwise increment the index.
  - PARITY: after CLKS_PER_BIT cycles, sample the parity bit and go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit. In that same cycle, register:
    - data <= shift register.
    - parity_err <= (XOR of 8 data bits) XOR parity bit. Even parity: total ones across data plus parity must be even.
    - frame_err <= ~stop bit.
    - Pulse data_valid=1 for exactly one cycle.
    - If the stop bit is 1, go to IDLE. If the stop bit is 0, go to BREAK.
  - BREAK: busy=1. Wait until rx_s=1, then go to IDLE. This prevents a held-low line or break from being re-detected as a start bit.
- data_valid pulses on every completed frame, including errored ones. The flags qualify the byte.
- Error flags are held until the next data_valid. They are not sticky across frames.
- Returning to IDLE at stop mid-bit (half a bit early) permits resync. A start edge immediately following is accepted.
- Measured from the synchronised falling edge, data_valid occurs HALF_BIT + 10*CLKS_PER_BIT cycles after START entry.
- No back-pressure: a new frame overwrites data. The consumer must capture on data_valid.
- Unknown state encodings recover to IDLE.

Test Plan:
- Send 0xA5 with parity 0 and stop 1 at 434 clk/bit → one data_valid pulse; data=0xA5, parity_err=0, frame_err=0; busy returns to 0.
- Send 0x07 with parity 1 → data=0x07, parity_err=0. Repeat with parity 0 → data=0x07, parity_err=1, frame_err=0.
- Send 0x3C with stop bit 0, then hold the line low for 2000 cycles → data_valid once, frame_err=1; busy stays 1 until the line rises, then IDLE; no second strobe.
- Drive a 100-cycle low glitch on idle line → no data_valid; busy high for ~217 cycles, then 0.
- Send back-to-back frames 0x55 then 0xFF with zero idle gap → two data_valid pulses in order; data=0x55 then 0xFF; both error flags 0.
- Assert rst for 5 cycles during data bit 4 of 0x81, then send 0x42 → no strobe for the aborted frame; outputs read 0 after reset; next strobe gives data=0x42 with clean flags.

Source files
------------

// File: rtl/uart_rx.sv
// 8E1 UART receiver: 2-flop input synchroniser, mid-bit sampling, one-cycle
// data_valid strobe with held parity and framing error flags.
module uart_rx #(
    parameter int BASE_FREQ = 50_000_000,
    parameter int BAUDRATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int CLKS_PER_BIT = BASE_FREQ / BAUDRATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam logic [31:0] BIT_LAST  = 32'(CLKS_PER_BIT - 1);
    localparam logic [31:0] HALF_LAST = 32'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_e;

    state_e      state_q;
    logic [1:0]  sync_q;
    logic [31:0] clk_ctr_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        par_q;
    logic [7:0]  data_q;
    logic        data_valid_q;
    logic        parity_err_q;
    logic        frame_err_q;
    logic        busy_q;
    logic        rx_s;

    assign rx_s       = sync_q[1];
    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            clk_ctr_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], serial_in};
            data_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q   <= START;
                        clk_ctr_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    if (clk_ctr_q == HALF_LAST) begin
                        clk_ctr_q <= '0;
                        // Line high again at mid-start: treat as a glitch.
                        if (rx_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        clk_ctr_q <= clk_ctr_q + 32'd1;
                    end
                end
                DATA: begin
                    if (clk_ctr_q == BIT_LAST) begin
                        clk_ctr_q          <= '0;
                        shift_q[bit_idx_q] <= rx_s;
                        if (bit_idx_q == 3'd7) state_q <= PARITY;
                        else                   bit_idx_q <= bit_idx_q + 3'd1;
                    end else begin
                        clk_ctr_q <= clk_ctr_q + 32'd1;
                    end
                end
                PARITY: begin
                    if (clk_ctr_q == BIT_LAST) begin
                        clk_ctr_q <= '0;
                        par_q     <= rx_s;
                        state_q   <= STOP;
                    end else begin
                        clk_ctr_q <= clk_ctr_q + 32'd1;
                    end
                end
                STOP: begin
                    if (clk_ctr_q == BIT_LAST) begin
                        clk_ctr_q    <= '0;
                        data_q       <= shift_q;
                        parity_err_q <= (^shift_q) ^ par_q;
                        frame_err_q  <= ~rx_s;
                        data_valid_q <= 1'b1;
                        // Leave at mid-stop so an immediately following start edge is caught.
                        state_q      <= rx_s ? IDLE : BREAK;
                        busy_q       <= ~rx_s;
                    end else begin
                        clk_ctr_q <= clk_ctr_q + 32'd1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    clk_ctr_q <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed 8E1 frames push expected bytes/flags,
// a negedge monitor pops and compares on every data_valid strobe.
module tb_uart_rx;
    localparam int CPB = 434;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic [7:0] data;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t  sb[$];
    exp_t  mon_e;
    int    checks;
    int    errors;
    longint t_start;
    longint first_dv_t;

    uart_rx dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .data       (data),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bit_out(input logic b);
        serial_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stop);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        bit_out(par);
        bit_out(stop);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d = d; e.pe = pe; e.fe = fe;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            if (first_dv_t == 0) first_dv_t = $time;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got data %0h, expected no strobe", data);
            end else begin
                mon_e = sb.pop_front();
                chk("data", {24'd0, data}, {24'd0, mon_e.d});
                chk("parity_err", {31'd0, parity_err}, {31'd0, mon_e.pe});
                chk("frame_err", {31'd0, frame_err}, {31'd0, mon_e.fe});
            end
        end
    end

    initial begin
        checks = 0; errors = 0; first_dv_t = 0; t_start = 0;
        rst = 1'b1; serial_in = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_data", {24'd0, data}, 32'h0);
        chk("rst_valid", {31'd0, data_valid}, 32'h0);
        chk("rst_perr", {31'd0, parity_err}, 32'h0);
        chk("rst_ferr", {31'd0, frame_err}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Clean frame plus latency from line edge to strobe (2 sync + 1 idle + 217 + 4340)
        expect_frame(8'hA5, 1'b0, 1'b0);
        t_start = $time;
        send(8'hA5, 1'b0, 1'b1);
        repeat (50) @(negedge clk);
        chk("latency_cycles", 32'((first_dv_t - t_start) / 10), 32'd4560);
        chk("busy_after_a5", {31'd0, busy}, 32'h0);

        // Parity good then bad
        expect_frame(8'h07, 1'b0, 1'b0);
        send(8'h07, 1'b1, 1'b1);
        expect_frame(8'h07, 1'b1, 1'b0);
        send(8'h07, 1'b0, 1'b1);
        repeat (50) @(negedge clk);

        // Framing error with held-low line
        expect_frame(8'h3C, 1'b0, 1'b1);
        send(8'h3C, 1'b0, 1'b0);
        serial_in = 1'b0;
        repeat (2000) @(negedge clk);
        chk("busy_in_break", {31'd0, busy}, 32'h1);
        serial_in = 1'b1;
        repeat (10) @(negedge clk);
        chk("busy_after_break", {31'd0, busy}, 32'h0);

        // Short glitch on idle line
        serial_in = 1'b0;
        repeat (100) @(negedge clk);
        serial_in = 1'b1;
        repeat (50) @(negedge clk);
        chk("busy_glitch_hi", {31'd0, busy}, 32'h1);
        repeat (150) @(negedge clk);
        chk("busy_glitch_lo", {31'd0, busy}, 32'h0);

        // Back-to-back frames, no idle gap
        expect_frame(8'h55, 1'b0, 1'b0);
        expect_frame(8'hFF, 1'b0, 1'b0);
        send(8'h55, 1'b0, 1'b1);
        send(8'hFF, 1'b0, 1'b1);
        repeat (50) @(negedge clk);

        // Reset during data bit 4 of 0x81 aborts the frame
        bit_out(1'b0);
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b0); bit_out(1'b0);
        serial_in = 1'b0;
        repeat (200) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_data", {24'd0, data}, 32'h0);
        chk("midrst_valid", {31'd0, data_valid}, 32'h0);
        chk("midrst_perr", {31'd0, parity_err}, 32'h0);
        chk("midrst_ferr", {31'd0, frame_err}, 32'h0);
        chk("midrst_busy", {31'd0, busy}, 32'h0);
        serial_in = 1'b1;
        rst = 1'b0;
        repeat (1000) @(negedge clk);
        expect_frame(8'h42, 1'b0, 1'b0);
        send(8'h42, 1'b0, 1'b1);
        repeat (50) @(negedge clk);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
